// File: rtl/gameplay_if.sv
// Signal bundle between the input-sync/datapath side (master) and the gameplay sequencer (slave).
interface gameplay_if;
  logic       start;
  logic       drop;
  logic       pause;
  logic       o;
  logic       c;
  logic       enable;
  logic       ld_y;
  logic       move_on;
  logic       inc_score;
  logic       dec_chances;
  logic [6:0] y_value;
  logic       clr;
  logic       game_over;
  logic [7:0] level;
  logic [3:0] state;

  modport master (
    output start, drop, pause, o, c,
    input  enable, ld_y, move_on, inc_score, dec_chances, y_value, clr, game_over, level, state
  );

  modport slave (
    input  start, drop, pause, o, c,
    output enable, ld_y, move_on, inc_score, dec_chances, y_value, clr, game_over, level, state
  );
endinterface

// File: rtl/gameplay_control.sv
// Sequencing FSM for the stacking game: starts a round, lets a block swing, commits it on drop,
// scores a hit or costs a chance on a miss, and ends the game when no chances remain.
module gameplay_control #(
  parameter logic [6:0] Y_BASE  = 7'd112,
  parameter logic [6:0] Y_TOP   = 7'd8,
  parameter logic [6:0] BLOCK_H = 7'd8,
  parameter logic [3:0] SETTLE  = 4'd2
) (
  input logic        clk,
  input logic        resetn,
  gameplay_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_LOAD    = 4'd1,
    S_SWING   = 4'd2,
    S_SETTLE  = 4'd3,
    S_CHECK   = 4'd4,
    S_HIT     = 4'd5,
    S_MISS    = 4'd6,
    S_MISSCHK = 4'd7,
    S_NEXT    = 4'd8,
    S_OVER    = 4'd9,
    S_CLEAR   = 4'd10
  } state_t;

  // A settle length of zero still spends one cycle in S_SETTLE.
  localparam logic [3:0] SETTLE_LAST = (SETTLE == 4'd0) ? 4'd0 : SETTLE - 4'd1;
  localparam logic [7:0] Y_WRAP_MIN  = {1'b0, Y_TOP} + {1'b0, BLOCK_H};

  state_t     st;
  logic       start_r;
  logic       drop_r;
  logic [3:0] settle_cnt;
  logic       enable_q;
  logic       ld_y_q;
  logic       move_on_q;
  logic       inc_score_q;
  logic       dec_chances_q;
  logic       clr_q;
  logic       game_over_q;
  logic [6:0] y_q;
  logic [7:0] level_q;

  logic       start_rise;
  logic       drop_rise;
  logic [7:0] y_ext;
  logic [7:0] y_dec;
  logic [6:0] y_after_hit;
  logic [7:0] level_after_hit;

  assign start_rise = bus.start & ~start_r;
  assign drop_rise  = bus.drop & ~drop_r;

  // Compare in 8 bits before subtracting so the row can never underflow; low rows wrap to the base.
  always_comb begin
    y_ext           = {1'b0, y_q};
    y_dec           = y_ext - {1'b0, BLOCK_H};
    y_after_hit     = (y_ext >= Y_WRAP_MIN) ? y_dec[6:0] : Y_BASE;
    level_after_hit = (level_q == 8'hFF) ? 8'hFF : level_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      st            <= S_IDLE;
      // Load the current input levels so an input held across reset does not look like an edge.
      start_r       <= bus.start;
      drop_r        <= bus.drop;
      settle_cnt    <= 4'd0;
      enable_q      <= 1'b0;
      ld_y_q        <= 1'b0;
      move_on_q     <= 1'b0;
      inc_score_q   <= 1'b0;
      dec_chances_q <= 1'b0;
      clr_q         <= 1'b0;
      game_over_q   <= 1'b0;
      y_q           <= Y_BASE;
      level_q       <= 8'd0;
    end else begin
      start_r       <= bus.start;
      drop_r        <= bus.drop;
      ld_y_q        <= 1'b0;
      move_on_q     <= 1'b0;
      inc_score_q   <= 1'b0;
      dec_chances_q <= 1'b0;
      clr_q         <= 1'b0;
      case (st)
        S_IDLE, S_OVER: begin
          if (start_rise) begin
            st          <= S_CLEAR;
            clr_q       <= 1'b1;
            game_over_q <= 1'b0;
            enable_q    <= 1'b0;
            y_q         <= Y_BASE;
            level_q     <= 8'd0;
          end
        end
        S_CLEAR: begin
          st     <= S_LOAD;
          ld_y_q <= 1'b1;
        end
        S_LOAD: begin
          st       <= S_SWING;
          enable_q <= ~bus.pause;
        end
        S_SWING: begin
          // A drop while paused is discarded rather than remembered.
          if (drop_rise && !bus.pause) begin
            st         <= S_SETTLE;
            settle_cnt <= 4'd0;
            enable_q   <= 1'b0;
          end else begin
            enable_q <= ~bus.pause;
          end
        end
        S_SETTLE: begin
          if (settle_cnt >= SETTLE_LAST) begin
            st <= S_CHECK;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CHECK: begin
          if ((level_q == 8'd0) || bus.o) begin
            st          <= S_HIT;
            inc_score_q <= 1'b1;
          end else begin
            st            <= S_MISS;
            dec_chances_q <= 1'b1;
          end
        end
        S_HIT: begin
          st        <= S_NEXT;
          move_on_q <= 1'b1;
          level_q   <= level_after_hit;
          y_q       <= y_after_hit;
        end
        S_NEXT: begin
          st     <= S_LOAD;
          ld_y_q <= 1'b1;
        end
        S_MISS: begin
          st <= S_MISSCHK;
        end
        S_MISSCHK: begin
          // c reflects the decrement issued in S_MISS by now.
          if (bus.c) begin
            st       <= S_SWING;
            enable_q <= ~bus.pause;
          end else begin
            st          <= S_OVER;
            game_over_q <= 1'b1;
            enable_q    <= 1'b0;
          end
        end
        default: begin
          st       <= S_IDLE;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.enable      = enable_q;
  assign bus.ld_y        = ld_y_q;
  assign bus.move_on     = move_on_q;
  assign bus.inc_score   = inc_score_q;
  assign bus.dec_chances = dec_chances_q;
  assign bus.clr         = clr_q;
  assign bus.game_over   = game_over_q;
  assign bus.y_value     = y_q;
  assign bus.level       = level_q;
  assign bus.state       = st;

endmodule

// File: tb/tb_gameplay_control.sv
// Directed bench for gameplay_control: start, hit, miss, pause, game over, restart, y wrap, reset.
module tb_gameplay_control;

  logic clk;
  logic resetn;
  logic mon_en;
  int   n_checks;
  int   n_pass;

  gameplay_if bus();

  gameplay_control dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) begin
      n_pass++;
    end else begin
      $display("FAIL %s: actual=%0d required=%0d", tag, actual, expected);
    end
  endtask

  // Advance one clock; outputs are sampled on the falling edge that follows.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Drop edge -> SETTLE x2 -> CHECK -> HIT/MISS
  task automatic drop_to_decision();
    bus.drop = 1'b1;
    tick();
    check("drop_settle_state", bus.state, 3);
    check("drop_settle_enable", bus.enable, 0);
    bus.drop = 1'b0;
    tick();
    check("settle_second_cycle", bus.state, 3);
    tick();
    check("check_state", bus.state, 4);
    tick();
  endtask

  task automatic do_hit(input logic [6:0] exp_y, input logic [7:0] exp_lvl);
    bus.o = 1'b1;
    drop_to_decision();
    check("hit_inc_score", bus.inc_score, 1);
    tick();
    check("hit_move_on", bus.move_on, 1);
    tick();
    check("hit_ld_y", bus.ld_y, 1);
    check("hit_y_value", bus.y_value, exp_y);
    check("hit_level", bus.level, exp_lvl);
    tick();
    check("hit_enable", bus.enable, 1);
  endtask

  // Strobe monitor: at most one strobe, and none in IDLE/SWING/SETTLE/OVER.
  always @(negedge clk) begin
    if (mon_en) begin
      check("strobe_onehot",
            ($countones({bus.clr, bus.ld_y, bus.move_on, bus.inc_score, bus.dec_chances}) <= 1), 1);
      if (bus.state inside {4'd0, 4'd2, 4'd3, 4'd9})
        check("strobe_quiet_state",
              {bus.clr, bus.ld_y, bus.move_on, bus.inc_score, bus.dec_chances}, 0);
    end
  end

  logic [6:0] exp_y;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    mon_en     = 1'b0;
    resetn     = 1'b0;
    bus.start  = 1'b0;
    bus.drop   = 1'b0;
    bus.pause  = 1'b0;
    bus.o      = 1'b0;
    bus.c      = 1'b1;
    ticks(2);
    check("rst_state", bus.state, 0);
    check("rst_enable", bus.enable, 0);
    check("rst_y", bus.y_value, 112);
    check("rst_level", bus.level, 0);
    check("rst_game_over", bus.game_over, 0);
    check("rst_clr", bus.clr, 0);
    mon_en = 1'b1;
    resetn = 1'b1;
    tick();

    // Start: clr, then ld_y with base row, then swing
    bus.start = 1'b1;
    tick();
    check("start_clr", bus.clr, 1);
    check("start_clear_state", bus.state, 10);
    bus.start = 1'b0;
    tick();
    check("start_ld_y", bus.ld_y, 1);
    check("start_y_base", bus.y_value, 112);
    tick();
    check("start_enable", bus.enable, 1);
    check("start_swing_state", bus.state, 2);

    // First block lands even with o=0
    bus.o = 1'b0;
    drop_to_decision();
    check("first_inc_score", bus.inc_score, 1);
    tick();
    check("first_move_on", bus.move_on, 1);
    tick();
    check("first_ld_y", bus.ld_y, 1);
    check("first_y", bus.y_value, 104);
    check("first_level", bus.level, 1);
    tick();
    check("first_enable", bus.enable, 1);

    // Miss with chances left: decrement, no move_on, back to swing
    bus.o = 1'b0;
    bus.c = 1'b1;
    drop_to_decision();
    check("miss_dec", bus.dec_chances, 1);
    check("miss_no_move_on", bus.move_on, 0);
    tick();
    check("misschk_state", bus.state, 7);
    check("misschk_dec_low", bus.dec_chances, 0);
    tick();
    check("miss_back_swing", bus.state, 2);
    check("miss_enable", bus.enable, 1);
    check("miss_level_kept", bus.level, 1);
    check("miss_y_kept", bus.y_value, 104);

    // Pause freezes swing and discards a drop edge
    bus.pause = 1'b1;
    tick();
    check("pause_enable", bus.enable, 0);
    bus.drop = 1'b1;
    tick();
    check("pause_drop_ignored", bus.state, 2);
    check("pause_enable_held", bus.enable, 0);
    bus.drop  = 1'b0;
    bus.pause = 1'b0;
    tick();
    check("unpause_enable", bus.enable, 1);
    tick();
    check("drop_not_queued", bus.state, 2);

    // Miss with no chances left -> game over
    bus.o = 1'b0;
    drop_to_decision();
    check("last_miss_dec", bus.dec_chances, 1);
    bus.c = 1'b0;
    tick();
    tick();
    check("over_state", bus.state, 9);
    check("over_game_over", bus.game_over, 1);
    check("over_enable", bus.enable, 0);
    tick();
    check("over_stays", bus.state, 9);

    // Restart from game over
    bus.c     = 1'b1;
    bus.start = 1'b1;
    tick();
    check("restart_clr", bus.clr, 1);
    check("restart_game_over_low", bus.game_over, 0);
    bus.start = 1'b0;
    tick();
    check("restart_ld_y", bus.ld_y, 1);
    check("restart_y", bus.y_value, 112);
    check("restart_level", bus.level, 0);
    tick();
    check("restart_enable", bus.enable, 1);

    // Fifteen hits: 13 steps down to row 8, 14th wraps to 112, 15th goes to 104
    for (int n = 1; n <= 15; n++) begin
      if (n <= 13)      exp_y = 7'(112 - 8 * n);
      else if (n == 14) exp_y = 7'd112;
      else              exp_y = 7'd104;
      do_hit(exp_y, 8'(n));
    end
    check("wrap_final_level", bus.level, 15);
    check("wrap_final_y", bus.y_value, 104);

    // Start and drop together in SWING: drop wins
    bus.o     = 1'b1;
    bus.start = 1'b1;
    bus.drop  = 1'b1;
    tick();
    check("simul_drop_wins", bus.state, 3);
    check("simul_no_clr", bus.clr, 0);
    bus.start = 1'b0;
    bus.drop  = 1'b0;

    // Reset in the middle of SETTLE
    resetn = 1'b0;
    tick();
    check("midrst_state", bus.state, 0);
    check("midrst_enable", bus.enable, 0);
    check("midrst_inc_score", bus.inc_score, 0);
    check("midrst_y", bus.y_value, 112);
    check("midrst_level", bus.level, 0);

    // A start held high through reset must not fire
    bus.start = 1'b1;
    tick();
    resetn = 1'b1;
    ticks(2);
    check("held_start_no_fire", bus.state, 0);
    check("held_start_no_clr", bus.clr, 0);
    bus.start = 1'b0;
    tick();
    bus.start = 1'b1;
    tick();
    check("fresh_start_clr", bus.clr, 1);
    bus.start = 1'b0;
    tick();

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
